// File: rtl/window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers supply the rows above the incoming pixel; window is registered.
module window_gen #(
   parameter int nbit  = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [nbit-1:0] pix_in,
   input  logic            pix_valid,
   output logic [nbit-1:0] P0,
   output logic [nbit-1:0] P1,
   output logic [nbit-1:0] P2,
   output logic [nbit-1:0] P3,
   output logic [nbit-1:0] P4,
   output logic [nbit-1:0] P5,
   output logic [nbit-1:0] P6,
   output logic [nbit-1:0] P7,
   output logic [nbit-1:0] P8,
   output logic            win_valid,
   output logic            frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [nbit-1:0] win_q [9];
   logic [nbit-1:0] win_d [9];
   logic            win_valid_q, win_valid_d;
   logic            frame_done_q, frame_done_d;

   // lb1 holds row r-1, lb0 holds row r-2; neither is reset since
   // win_valid stays low until both hold rows of the current frame.
   logic [nbit-1:0] lb0_q [IMG_W];
   logic [nbit-1:0] lb1_q [IMG_W];
   logic [nbit-1:0] lb0_rd, lb1_rd;

   assign lb0_rd = lb0_q[col_q];
   assign lb1_rd = lb1_q[col_q];

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (pix_valid) begin
         for (int k = 0; k < 3; k++) begin
            win_d[3*k]   = win_q[3*k+1];
            win_d[3*k+1] = win_q[3*k+2];
         end
         win_d[2]     = lb0_rd;
         win_d[5]     = lb1_rd;
         win_d[8]     = pix_in;
         win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
         frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

   // The pixel arriving with reset is dropped, so it must not enter the buffers either.
   always_ff @(posedge clk) begin
      if (pix_valid && !rst) begin
         lb0_q[col_q] <= lb1_rd;
         lb1_q[col_q] <= pix_in;
      end
   end

   assign P0         = win_q[0];
   assign P1         = win_q[1];
   assign P2         = win_q[2];
   assign P3         = win_q[3];
   assign P4         = win_q[4];
   assign P5         = win_q[5];
   assign P6         = win_q[6];
   assign P7         = win_q[7];
   assign P8         = win_q[8];
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on a 4x4 image: a reference model pushes
// expected windows to a scoreboard queue as pixels are driven; tasks pop and compare.
module tb_window_gen;

   typedef struct packed {
      logic            fd;
      logic [8:0][7:0] w;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] pix_in;
   logic       pix_valid;
   logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
   logic       win_valid;
   logic       frame_done;
   logic [8:0][7:0] dut_w;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t       sb [$];
   logic       exp_now;
   logic [7:0] m_img [4][4];
   int         m_row, m_col;

   int              obs_pulses;
   int              obs_fd_cnt;
   logic [7:0]      obs_fd_p8;
   logic [8:0][7:0] obs_first;
   logic [7:0]      obs_p8 [$];

   logic [8:0][7:0] first_w0;
   logic [8:0][7:0] first_w100;
   logic [7:0]      p8_tab [4];

   window_gen #(.nbit(8), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
      .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
      .win_valid(win_valid), .frame_done(frame_done)
   );

   assign dut_w = {P8, P7, P6, P5, P4, P3, P2, P1, P0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle; the model updates on accepted pixels and queues expected windows.
   task automatic step(input logic v, input logic [7:0] d);
      exp_t e;
      pix_valid = v;
      pix_in    = d;
      exp_now   = 1'b0;
      @(posedge clk);
      if (rst) begin
         m_row = 0;
         m_col = 0;
         sb.delete();
      end else if (v) begin
         m_img[m_row][m_col] = d;
         if (m_row >= 2 && m_col >= 2) begin
            for (int k = 0; k < 9; k++) begin
               e.w[k] = m_img[m_row - 2 + k / 3][m_col - 2 + k % 3];
            end
            e.fd = (m_row == 3) && (m_col == 3);
            sb.push_back(e);
            exp_now = 1'b1;
         end
         if (m_col == 3) begin
            m_col = 0;
            m_row = (m_row == 3) ? 0 : m_row + 1;
         end else begin
            m_col = m_col + 1;
         end
      end
      #1;
      pix_valid = 1'b0;
   endtask

   // One 4x4 frame of value off+4*row+col, with gap idle cycles after each pixel.
   task automatic run_frame(input int off, input int gap);
      exp_t            e;
      logic            held_ok;
      logic [8:0][7:0] last_w;
      obs_pulses = 0;
      obs_fd_cnt = 0;
      obs_fd_p8  = '0;
      obs_first  = '0;
      obs_p8.delete();
      held_ok    = 1'b0;
      last_w     = '0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(off + i));
         n_cmp++;
         if (win_valid !== exp_now) begin
            n_fail++;
            $display("FAIL win_valid pix=%0d got=%b exp=%b", i, win_valid, exp_now);
         end
         if (win_valid === 1'b1) begin
            if (obs_pulses == 0) obs_first = dut_w;
            obs_pulses++;
            obs_p8.push_back(P8);
         end
         if (frame_done === 1'b1) begin
            obs_fd_cnt++;
            obs_fd_p8 = P8;
         end
         if (exp_now && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dut_w !== e.w || frame_done !== e.fd) begin
               n_fail++;
               $display("FAIL window pix=%0d got=%h fd=%b exp=%h fd=%b",
                        i, dut_w, frame_done, e.w, e.fd);
            end
            last_w  = e.w;
            held_ok = 1'b1;
         end else begin
            held_ok = 1'b0;
            n_cmp++;
            if (frame_done !== 1'b0) begin
               n_fail++;
               $display("FAIL frame_done pix=%0d got=%b exp=0", i, frame_done);
            end
         end
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 8'($urandom));
            n_cmp++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_flags pix=%0d got wv=%b fd=%b exp=0", i, win_valid, frame_done);
            end
            if (held_ok) begin
               n_cmp++;
               if (dut_w !== last_w) begin
                  n_fail++;
                  $display("FAIL idle_hold pix=%0d got=%h exp=%h", i, dut_w, last_w);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b1, 8'hAA);
      step(1'b1, 8'h55);
      n_cmp++;
      if (dut_w !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got=%h wv=%b fd=%b exp=0", dut_w, win_valid, frame_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_first_window();
      run_frame(0, 0);
      n_cmp++;
      if (obs_first !== first_w0) begin
         n_fail++;
         $display("FAIL first_window got=%h exp=%h", obs_first, first_w0);
      end
   endtask

   task automatic test_window_count();
      run_frame(0, 0);
      n_cmp++;
      if (obs_pulses != 4) begin
         n_fail++;
         $display("FAIL win_count got=%0d exp=4", obs_pulses);
      end
      for (int j = 0; j < obs_p8.size() && j < 4; j++) begin
         n_cmp++;
         if (obs_p8[j] !== p8_tab[j]) begin
            n_fail++;
            $display("FAIL win_p8 idx=%0d got=%0d exp=%0d", j, obs_p8[j], p8_tab[j]);
         end
      end
      n_cmp++;
      if (obs_fd_cnt != 1 || obs_fd_p8 !== 8'd15) begin
         n_fail++;
         $display("FAIL frame_done_pos got cnt=%0d p8=%0d exp cnt=1 p8=15", obs_fd_cnt, obs_fd_p8);
      end
   endtask

   task automatic test_gaps();
      run_frame(0, 3);
      n_cmp++;
      if (obs_pulses != 4 || obs_first !== first_w0) begin
         n_fail++;
         $display("FAIL gaps_windows got cnt=%0d first=%h exp cnt=4 first=%h",
                  obs_pulses, obs_first, first_w0);
      end
      for (int j = 0; j < obs_p8.size() && j < 4; j++) begin
         n_cmp++;
         if (obs_p8[j] !== p8_tab[j]) begin
            n_fail++;
            $display("FAIL gaps_p8 idx=%0d got=%0d exp=%0d", j, obs_p8[j], p8_tab[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_frame(0, 0);
      run_frame(100, 0);
      n_cmp++;
      if (obs_pulses != 4 || obs_first !== first_w100) begin
         n_fail++;
         $display("FAIL b2b_first got cnt=%0d first=%h exp cnt=4 first=%h",
                  obs_pulses, obs_first, first_w100);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 8'(200 + i));
      end
      rst = 1'b1;
      step(1'b1, 8'd77);
      rst = 1'b0;
      n_cmp++;
      if (dut_w !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state got=%h wv=%b fd=%b exp=0", dut_w, win_valid, frame_done);
      end
      run_frame(0, 0);
      n_cmp++;
      if (obs_pulses != 4 || obs_first !== first_w0 || obs_fd_cnt != 1 || obs_fd_p8 !== 8'd15) begin
         n_fail++;
         $display("FAIL midreset_frame got cnt=%0d first=%h fd=%0d/%0d exp cnt=4 first=%h fd=1/15",
                  obs_pulses, obs_first, obs_fd_cnt, obs_fd_p8, first_w0);
      end
      for (int j = 0; j < obs_p8.size() && j < 4; j++) begin
         n_cmp++;
         if (obs_p8[j] !== p8_tab[j]) begin
            n_fail++;
            $display("FAIL midreset_p8 idx=%0d got=%0d exp=%0d", j, obs_p8[j], p8_tab[j]);
         end
      end
   endtask

   initial begin
      first_w0   = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
      first_w100 = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
      p8_tab     = '{8'd10, 8'd11, 8'd14, 8'd15};
      rst        = 1'b1;
      pix_valid  = 1'b0;
      pix_in     = '0;
      exp_now    = 1'b0;
      m_row      = 0;
      m_col      = 0;
      #1;
      test_reset();
      test_first_window();
      test_window_count();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty got=%0d exp=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter nbit, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per image row (>=3).
REQ-003 SHALL have parameter IMG_H, default 480, rows per frame (>=3).
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pix_in  input  nbit  incoming raster pixel, row-major, left-to-right, top-to-bottom.
REQ-007 SHALL have port pix_valid  input  1  pix_in is accepted on this rising edge.
REQ-008 SHALL have ports P0..P8  output  nbit each  3x3 window; P0 P1 P2 top row, P3 P4 P5 middle row, P6 P7 P8 bottom row, left to right.
REQ-009 SHALL have port win_valid  output  1  P0..P8 hold a complete in-image window this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse: last pixel of the frame was accepted.

Function
REQ-011 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), width $clog2 of the range, both advanced only on accepted pixels.
REQ-012 SHALL increment col on each accepted pixel; at col=IMG_W-1, col wraps to 0 and row increments; at row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
REQ-013 SHALL hold two line buffers of IMG_W words, lb1 = row r-1 and lb0 = row r-2, both addressed by col.
REQ-014 SHALL, on an accepted pixel, read lb0[col] and lb1[col], then write lb0[col] <= old lb1[col] and lb1[col] <= pix_in, all on the same edge.
REQ-015 SHALL, on the same edge, shift the window left one column (P0<=P1, P1<=P2, P3<=P4, P4<=P5, P6<=P7, P7<=P8) and load the new right column P2<=lb0[col], P5<=lb1[col], P8<=pix_in.
REQ-016 SHALL have latency 1: the window containing pixel (r,c) at P8 is visible in the cycle after the edge that accepts (r,c).
REQ-017 SHALL set win_valid=1 for exactly that one cycle when the accepted pixel had row>=2 and col>=2, else 0; window centre P4 is pixel (row-1, col-1).
REQ-018 SHALL produce exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per frame; no window straddles a row boundary or a frame boundary.
REQ-019 SHALL hold P0..P8, counters and line buffers unchanged, and drive win_valid=0, when pix_valid=0; arbitrary gaps between pixels are legal.
REQ-020 SHALL pulse frame_done=1 for one cycle after the edge accepting pixel (IMG_H-1, IMG_W-1), coincident with that pixel's win_valid.
REQ-021 SHALL carry no backpressure; every pixel presented with pix_valid=1 is consumed.
REQ-022 SHALL treat pixel values as unsigned and pass them through unmodified, with no arithmetic on pixel data.

Reset
REQ-023 SHALL, on a rising edge with rst=1, clear col, row, win_valid, frame_done and P0..P8 to 0; rst overrides a simultaneous pix_valid, and that pixel is dropped.
REQ-024 SHALL NOT need reset of line-buffer contents; stale data is never exposed, because win_valid is gated by row>=2 and col>=2.
REQ-025 SHALL treat the first accepted pixel after reset, including mid-frame reset, as pixel (0,0) of a new frame.

Verification (IMG_W=4, IMG_H=4, nbit=8, pixel value = 4*row+col)
REQ-026 SHALL check the first window: stream 16 pixels back-to-back -> first win_valid is the cycle after pixel 10 is accepted, with P0..P8 = 0,1,2,4,5,6,8,9,10.
REQ-027 SHALL check the window count: the same frame -> exactly 4 win_valid pulses, with P8 = 10,11,14,15; frame_done is high only with P8=15.
REQ-028 SHALL check gaps: insert 3 idle cycles after every pixel -> identical window sequence and values; win_valid=0 during idle cycles; outputs are held.
REQ-029 SHALL check back-to-back frames: stream two frames, second offset by +100 -> second frame's first window is 100,101,102,104,105,106,108,109,110, with no window mixing the two frames.
REQ-030 SHALL check mid-frame reset: assert rst for 1 cycle with pix_valid=1 after 7 pixels, then a full frame -> all outputs 0 the cycle after reset; the pixel at reset is dropped; the following frame matches REQ-026 and REQ-027.
